// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states, default frame width and
// the bit-counter sizing helper used by both SPI ends.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_if.sv
// SPI serial pins plus the parallel TX/RX side of the responder.
interface spi_if import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH
) ();

    logic             SCLK;
    logic             SS_N;
    logic             MOSI;
    logic             MISO;
    logic             MISO_OE;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             TX_UNDERRUN;
    logic             BUSY;

    modport slave (
        input  SCLK, SS_N, MOSI, TX_DATA, TX_VALID,
        output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );

    modport master (
        output SCLK, SS_N, MOSI, TX_DATA, TX_VALID,
        input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with registered
// rise/fall pulses derived from the synchronised level.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;

    // synchroniser chain, delayed copy and edge pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            prev_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
        end
    end

    assign q    = sync_r[SYNC_STAGES-1];
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, oversampled in the clk domain, with a one-deep
// TX buffer and a one-cycle RX strobe.
module spi_slave import spi_pkg::*; #(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    spi_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
    logic ss_rise_s, ss_fall_s, ss_lvl_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .nrst(nrst), .d(bus.SCLK),
        .q(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .nrst(nrst), .d(bus.SS_N),
        .q(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .nrst(nrst), .d(bus.MOSI),
        .q(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_s = ^{sclk_lvl_s, ss_lvl_s, mosi_rise_s, mosi_fall_s};

    spi_state_e       state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] rx_shift_r, rx_shift_s;
    logic [WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic [WIDTH-1:0] rx_data_r, rx_data_s;
    logic [WIDTH-1:0] buf_r, buf_s;
    logic             buf_full_r, buf_full_s;
    logic             rx_valid_r, rx_valid_s;
    logic             underrun_r, underrun_s;
    logic             miso_r, miso_s;
    logic             miso_oe_r, miso_oe_s;
    logic             load_s;
    logic             wr_s;

    // next-state, shifting and TX buffer logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rx_shift_s = rx_shift_r;
        tx_shift_s = tx_shift_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        load_s     = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (ss_fall_s) begin
                    load_s  = 1'b1;
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cnt_r == CNT_FULL) begin
                    rx_data_s  = rx_shift_r;
                    rx_valid_s = 1'b1;
                    cnt_s      = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r;
                end
                // SS_N release wins over any SCLK edge in the same cycle
                if (ss_rise_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (sclk_rise_s) begin
                    rx_shift_s = {rx_shift_r[WIDTH-2:0], mosi_s};
                    cnt_s      = cnt_r + CNT_ONE;
                end else if (sclk_fall_s) begin
                    if (cnt_r != CNT_ZERO) begin
                        tx_shift_s = {tx_shift_r[WIDTH-2:0], 1'b0};
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // a load sees the buffer as it was before any same-cycle write
        underrun_s = load_s & ~buf_full_r;
        if (load_s) begin
            tx_shift_s = buf_full_r ? buf_r : {WIDTH{1'b0}};
        end else begin
            tx_shift_s = tx_shift_s;
        end

        wr_s       = bus.TX_VALID & ~buf_full_r;
        buf_s      = wr_s ? bus.TX_DATA : buf_r;
        buf_full_s = wr_s | (buf_full_r & ~load_s);

        miso_oe_s = (state_s == ACTIVE);
        miso_s    = (state_s == ACTIVE) ? tx_shift_s[WIDTH-1] : 1'b0;
    end

    // state and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            rx_shift_r <= {WIDTH{1'b0}};
            tx_shift_r <= {WIDTH{1'b0}};
            rx_data_r  <= {WIDTH{1'b0}};
            buf_r      <= {WIDTH{1'b0}};
            buf_full_r <= 1'b0;
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            rx_shift_r <= rx_shift_s;
            tx_shift_r <= tx_shift_s;
            rx_data_r  <= rx_data_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            rx_valid_r <= rx_valid_s;
            underrun_r <= underrun_s;
            miso_r     <= miso_s;
            miso_oe_r  <= miso_oe_s;
        end
    end

    assign bus.MISO        = miso_r;
    assign bus.MISO_OE     = miso_oe_r;
    assign bus.TX_READY    = ~buf_full_r;
    assign bus.RX_DATA     = rx_data_r;
    assign bus.RX_VALID    = rx_valid_r;
    assign bus.TX_UNDERRUN = underrun_r;
    assign bus.BUSY        = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus hand-written
// reset, back-to-back, abort and idle-noise sequences; SCLK = clk/8.
module tb_spi_slave;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    spi_if #(.WIDTH(8)) bus ();

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         rx_pulses  = 0;
    int         ur_pulses  = 0;
    int         oe_cycles  = 0;
    logic [7:0] rx_last    = 8'h00;
    logic [7:0] rx_prev    = 8'h00;

    // count strobe cycles and log received frames
    always @(negedge clk) begin
        if (bus.RX_VALID) begin
            rx_pulses <= rx_pulses + 1;
            rx_prev   <= rx_last;
            rx_last   <= bus.RX_DATA;
        end
        if (bus.TX_UNDERRUN) ur_pulses <= ur_pulses + 1;
        if (bus.MISO_OE)     oe_cycles <= oe_cycles + 1;
    end

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         has_tx;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        bus.TX_DATA  = d;
        bus.TX_VALID = 1'b1;
        @(negedge clk);
        bus.TX_VALID = 1'b0;
    endtask

    task automatic start_frame();
        bus.SS_N = 1'b0;
        cycles(8);
    endtask

    // master side: MSB first, SS_N released together with the final SCLK fall
    task automatic frame(input logic [7:0] mosi, input int nbits, input bit end_ss,
                         output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = mosi[7-i];
            cycles(4);
            bus.SCLK = 1'b1;
            miso = {miso[6:0], bus.MISO};
            cycles(4);
            bus.SCLK = 1'b0;
            if (end_ss && (i == nbits - 1)) bus.SS_N = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int         rx0;
        int         ur0;
        int         oe0;

        vecs[0] = '{8'hAA, 8'h5C, 1'b1, 8'h5C, 8'hAA, 0};
        vecs[1] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00, 0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 8'h01, 8'hFF, 0};
        vecs[3] = '{8'h3C, 8'h99, 1'b0, 8'h00, 8'h3C, 1};
        vecs[4] = '{8'h81, 8'hA5, 1'b1, 8'hA5, 8'h81, 0};

        nrst         = 1'b0;
        bus.SCLK     = 1'b0;
        bus.SS_N     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.TX_DATA  = 8'h00;
        bus.TX_VALID = 1'b0;
        cycles(3);
        check("rst_miso",     bus.MISO,        1'b0);
        check("rst_miso_oe",  bus.MISO_OE,     1'b0);
        check("rst_tx_ready", bus.TX_READY,    1'b1);
        check("rst_rx_data",  bus.RX_DATA,     8'h00);
        check("rst_rx_valid", bus.RX_VALID,    1'b0);
        check("rst_underrun", bus.TX_UNDERRUN, 1'b0);
        check("rst_busy",     bus.BUSY,        1'b0);
        nrst = 1'b1;
        cycles(4);

        // reset asserted in the middle of a frame
        tx_write(8'h77);
        start_frame();
        frame(8'hC3, 3, 1'b0, m1);
        check("mid_miso_bits", m1, 8'h03);
        check("mid_busy",      bus.BUSY, 1'b1);
        check("mid_oe",        bus.MISO_OE, 1'b1);
        nrst = 1'b0;
        #1;
        check("arst_oe",       bus.MISO_OE,  1'b0);
        check("arst_busy",     bus.BUSY,     1'b0);
        check("arst_tx_ready", bus.TX_READY, 1'b1);
        check("arst_miso",     bus.MISO,     1'b0);
        bus.SS_N = 1'b1;
        bus.SCLK = 1'b0;
        cycles(3);
        nrst = 1'b1;
        cycles(4);
        rx0 = rx_pulses;
        start_frame();
        frame(8'hAA, 8, 1'b1, m1);
        cycles(8);
        check("post_rst_rx",    bus.RX_DATA, 8'hAA);
        check("post_rst_pulse", rx_pulses - rx0, 1);

        // single full-duplex frames from the table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].has_tx) begin
                tx_write(vecs[v].tx);
                check("tbl_ready_low", bus.TX_READY, 1'b0);
            end
            rx0 = rx_pulses;
            ur0 = ur_pulses;
            start_frame();
            check("tbl_ready_after_load", bus.TX_READY, 1'b1);
            check("tbl_busy", bus.BUSY, 1'b1);
            frame(vecs[v].mosi, 8, 1'b1, m1);
            cycles(8);
            check("tbl_miso",     m1, vecs[v].exp_miso);
            check("tbl_rx_data",  bus.RX_DATA, vecs[v].exp_rx);
            check("tbl_rx_pulse", rx_pulses - rx0, 1);
            check("tbl_underrun", ur_pulses - ur0, vecs[v].exp_ur);
            check("tbl_oe_idle",  bus.MISO_OE, 1'b0);
        end

        // back-to-back frames with SS_N held low
        tx_write(8'h12);
        rx0 = rx_pulses;
        ur0 = ur_pulses;
        start_frame();
        fork
            frame(8'hF0, 8, 1'b0, m1);
            begin
                cycles(20);
                tx_write(8'h34);
            end
        join
        frame(8'h0F, 8, 1'b1, m2);
        cycles(8);
        check("b2b_miso1",    m1, 8'h12);
        check("b2b_miso2",    m2, 8'h34);
        check("b2b_pulses",   rx_pulses - rx0, 2);
        check("b2b_rx1",      rx_prev, 8'hF0);
        check("b2b_rx2",      rx_last, 8'h0F);
        check("b2b_underrun", ur_pulses - ur0, 0);

        // abort after five SCLK rises
        rx0 = rx_pulses;
        start_frame();
        frame(8'hFF, 5, 1'b1, m1);
        cycles(8);
        check("abort_pulses", rx_pulses - rx0, 0);
        check("abort_rx",     bus.RX_DATA, 8'h0F);
        check("abort_oe",     bus.MISO_OE, 1'b0);
        check("abort_busy",   bus.BUSY, 1'b0);
        rx0 = rx_pulses;
        start_frame();
        frame(8'h81, 8, 1'b1, m1);
        cycles(8);
        check("after_abort_rx",    bus.RX_DATA, 8'h81);
        check("after_abort_pulse", rx_pulses - rx0, 1);
        check("after_abort_miso",  m1, 8'h00);

        // SCLK noise while deselected
        tx_write(8'h66);
        check("noise_ready_pre", bus.TX_READY, 1'b0);
        rx0 = rx_pulses;
        oe0 = oe_cycles;
        for (int k = 0; k < 16; k++) begin
            bus.MOSI = k[0];
            bus.SCLK = 1'b1;
            cycles(4);
            bus.SCLK = 1'b0;
            cycles(4);
        end
        cycles(4);
        check("noise_pulses", rx_pulses - rx0, 0);
        check("noise_oe",     oe_cycles - oe0, 0);
        check("noise_ready",  bus.TX_READY, 1'b0);
        check("noise_busy",   bus.BUSY, 1'b0);
        start_frame();
        frame(8'h5A, 8, 1'b1, m1);
        cycles(8);
        check("noise_buf_kept", m1, 8'h66);
        check("noise_rx",       bus.RX_DATA, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
